register_ce: RTL and testbench

//  Single-clock, clock-enabled storage register of parameterisable width with a

---
 rtl/register_ce.sv | 54 +++++
 tb/tb_register_ce.sv | 108 ++++++++++
 2 files changed

// File: rtl/register_ce.sv
// Clock-enabled storage register with synchronous active-high reset to a constant.
// Output is the stored value only; it powers up holding RESET_VALUE.
module register_ce #(
    parameter int unsigned WORD_WIDTH = 0,
    localparam int unsigned WIDTH = (WORD_WIDTH >= 1) ? WORD_WIDTH : 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    // Declaration initialiser gives a defined value before any reset pulse.
    logic [WIDTH-1:0] data_q = RESET_VALUE;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= RESET_VALUE;
        end else if (clk_en) begin
            data_q <= i_data;
        end
    end

    assign o_data = data_q;

`ifdef FORMAL
    logic past_valid = 1'b0;

    always_ff @(posedge clk) begin
        past_valid <= 1'b1;
    end

    always_comb begin
        if (!past_valid) begin
            assert (o_data == RESET_VALUE);
        end
    end

    always_ff @(posedge clk) begin
        if (past_valid) begin
            if ($past(reset)) begin
                assert (o_data == RESET_VALUE);
            end else if ($past(clk_en)) begin
                assert (o_data == $past(i_data));
            end else begin
                assert ($stable(o_data));
            end
        end
    end
`endif

endmodule

// File: tb/tb_register_ce.sv
// Directed self-checking bench for register_ce: an 8-bit instance and a 1-bit flag instance.
module tb_register_ce;

    logic       clk = 1'b0;
    logic       reset8 = 1'b0;
    logic       en8 = 1'b0;
    logic [7:0] d8 = 8'h00;
    logic [7:0] q8;
    logic       reset1 = 1'b0;
    logic       en1 = 1'b0;
    logic [0:0] d1 = 1'b0;
    logic [0:0] q1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    register_ce #(.WORD_WIDTH(8), .RESET_VALUE(8'hA5)) dut8 (
        .clk    (clk),
        .reset  (reset8),
        .clk_en (en8),
        .i_data (d8),
        .o_data (q8)
    );

    register_ce #(.WORD_WIDTH(1), .RESET_VALUE(1'b1)) dut1 (
        .clk    (clk),
        .reset  (reset1),
        .clk_en (en1),
        .i_data (d1),
        .o_data (q1)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Power-up value without any reset
        #1;
        check("pwrup8", 16'(q8), 16'h00A5);
        check("pwrup1", 16'(q1), 16'h0001);

        // Reset with enable low, then load after release
        reset8 = 1'b1; en8 = 1'b0; d8 = 8'h3C;
        tick();
        check("rst_hold_en0", 16'(q8), 16'h00A5);
        reset8 = 1'b0; en8 = 1'b1;
        tick();
        check("load_after_rst", 16'(q8), 16'h003C);

        // Consecutive loads follow one cycle late
        d8 = 8'h01; tick(); check("seq01", 16'(q8), 16'h0001);
        d8 = 8'h02; tick(); check("seq02", 16'(q8), 16'h0002);
        d8 = 8'h03; tick(); check("seq03", 16'(q8), 16'h0003);

        // Hold while data toggles with enable low, checked mid-cycle and after edges
        d8 = 8'h55; tick(); check("load55", 16'(q8), 16'h0055);
        en8 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d8 = (i % 2 == 0) ? 8'hFF : 8'h00;
            #3;
            check($sformatf("hold_mid%0d", i), 16'(q8), 16'h0055);
            tick();
            check($sformatf("hold_edge%0d", i), 16'(q8), 16'h0055);
        end

        // Reset overrides enable, held several cycles, then normal load
        reset8 = 1'b1; en8 = 1'b1; d8 = 8'hFF;
        tick(); check("rst_wins", 16'(q8), 16'h00A5);
        d8 = 8'h12;
        tick(); check("rst_held1", 16'(q8), 16'h00A5);
        tick(); check("rst_held2", 16'(q8), 16'h00A5);
        reset8 = 1'b0; d8 = 8'h7E;
        tick(); check("load_after_rst2", 16'(q8), 16'h007E);
        en8 = 1'b0; d8 = 8'h81;
        tick(); check("hold_after_rst2", 16'(q8), 16'h007E);

        // 1-bit flag register
        en1 = 1'b1; d1 = 1'b0;
        tick(); check("flag_load0_pre", 16'(q1), 16'h0000);
        reset1 = 1'b1; en1 = 1'b0; d1 = 1'b0;
        tick(); check("flag_rst", 16'(q1), 16'h0001);
        reset1 = 1'b0; en1 = 1'b1; d1 = 1'b0;
        tick(); check("flag_load0", 16'(q1), 16'h0000);
        en1 = 1'b0; d1 = 1'b1;
        tick(); check("flag_hold0", 16'(q1), 16'h0000);
        tick(); check("flag_hold0b", 16'(q1), 16'h0000);
        en1 = 1'b1;
        tick(); check("flag_load1", 16'(q1), 16'h0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
